// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the uart transmit arbiter and its round-robin picker.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_e;

  localparam int DEFAULT_START_TIMEOUT = 16;

  // Next round-robin pointer with an explicit wrap, so non-power-of-2 counts work.
  function automatic logic [2:0] rr_next(input logic [2:0] ptr, input int n);
    return (int'(ptr) >= n - 1) ? 3'd0 : ptr + 3'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick_oh,
  output logic               found
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] cand;

  always_comb begin
    pick_oh = '0;
    found   = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
      cand = sum[PTR_W-1:0];
      if (!found && req[cand]) begin
        pick_oh[cand] = 1'b1;
        found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart transmitter among NUM_REQ byte producers, one byte per grant,
// with an optional per-requester lock that keeps multi-byte messages together.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int START_TIMEOUT = DEFAULT_START_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_lock,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 uart_transmit,
  output logic [7:0]           uart_tx_byte,
  input  logic                 uart_tx_busy,
  output logic                 timeout_err,
  output arb_state_e           dbg_state
);

  // Handshake: a byte moves when req_valid[i] is high in IDLE with the uart idle and
  // i wins the pick; req_ready[i] then pulses for one cycle and req_data is not used again.
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(START_TIMEOUT + 1);

  arb_state_e         state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d, owner_q, owner_d, pick_idx, sel_idx;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] pick_oh, grant_d, ready_d;
  logic               pick_found, transmit_d, timeout_d, do_release;
  logic [7:0]         byte_d, sel_byte;

  rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr_pick (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .pick_oh (pick_oh),
    .found   (pick_found)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick_oh[i]) pick_idx = PTR_W'(i);
    sel_idx  = (|grant) ? owner_q : pick_idx;
    sel_byte = 8'h00;
    for (int i = 0; i < NUM_REQ; i++)
      if (sel_idx == PTR_W'(i)) sel_byte = req_data[8*i +: 8];
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    grant_d    = grant;
    ready_d    = '0;
    transmit_d = 1'b0;
    timeout_d  = 1'b0;
    byte_d     = uart_tx_byte;
    do_release = 1'b0;
    case (state_q)
      IDLE: begin
        if (!uart_tx_busy) begin
          if (|grant) begin
            if (!req_lock[owner_q]) begin
              do_release = 1'b1;
            end else if (req_valid[owner_q]) begin
              ready_d = grant;
              byte_d  = sel_byte;
              state_d = LAUNCH;
            end
          end else if (pick_found) begin
            ready_d = pick_oh;
            grant_d = pick_oh;
            owner_d = pick_idx;
            byte_d  = sel_byte;
            state_d = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        transmit_d = 1'b1;
        cnt_d      = '0;
        state_d    = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (uart_tx_busy) begin
          state_d = WAIT_DONE;
        end else begin
          cnt_d = (cnt_q == CNT_W'(START_TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
          if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
            timeout_d  = 1'b1;
            do_release = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!uart_tx_busy) begin
          do_release = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A held lock keeps the owner and leaves the rotation pointer where it was.
    if (do_release && !req_lock[owner_q]) begin
      grant_d  = '0;
      rr_ptr_d = PTR_W'(rr_next(3'(owner_q), NUM_REQ));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      cnt_q         <= '0;
      grant         <= '0;
      req_ready     <= '0;
      uart_transmit <= 1'b0;
      timeout_err   <= 1'b0;
      uart_tx_byte  <= 8'h00;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      cnt_q         <= cnt_d;
      grant         <= grant_d;
      req_ready     <= ready_d;
      uart_transmit <= transmit_d;
      timeout_err   <= timeout_d;
      uart_tx_byte  <= byte_d;
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (3 requesters) with a busy-line uart model
// and a scoreboard of expected strobes {grant, byte}.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int N      = 3;
  localparam int TMO    = 16;
  localparam int BYTE_T = 10;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_lock, req_ready, grant;
  logic [8*N-1:0] req_data;
  logic           uart_transmit, uart_tx_busy, timeout_err;
  logic [7:0]     uart_tx_byte;
  arb_state_e     dbg_state;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .START_TIMEOUT(TMO)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_lock      (req_lock),
    .req_ready     (req_ready),
    .grant         (grant),
    .uart_transmit (uart_transmit),
    .uart_tx_byte  (uart_tx_byte),
    .uart_tx_busy  (uart_tx_busy),
    .timeout_err   (timeout_err),
    .dbg_state     (dbg_state)
  );

  // uart model: busy rises the cycle after a strobe and stays high BYTE_T cycles
  logic model_en;
  logic model_busy;
  int   busy_left;
  always @(posedge clk) begin
    if (reset) begin
      model_busy <= 1'b0;
      busy_left  <= 0;
    end else if (uart_transmit && model_en) begin
      model_busy <= 1'b1;
      busy_left  <= BYTE_T;
    end else if (busy_left > 0) begin
      busy_left <= busy_left - 1;
      if (busy_left == 1) model_busy <= 1'b0;
    end
  end
  assign uart_tx_busy = model_busy;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  sq0[$], sq1[$], sq2[$];
  logic [N-1:0] lk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_tx(input logic [2:0] g, input logic [7:0] b);
    exp_q.push_back({5'b0, g, b});
  endtask

  task automatic drive();
    req_valid = {sq2.size() > 0, sq1.size() > 0, sq0.size() > 0};
    req_data  = {(sq2.size() > 0) ? sq2[0] : 8'h00,
                 (sq1.size() > 0) ? sq1[0] : 8'h00,
                 (sq0.size() > 0) ? sq0[0] : 8'h00};
    req_lock  = lk & req_valid;
  endtask

  // One clock: requesters react to req_ready after the edge, then outputs are checked mid-cycle.
  task automatic tick();
    logic [15:0] e;
    @(posedge clk); #1;
    if (req_ready[0] && sq0.size() > 0) void'(sq0.pop_front());
    if (req_ready[1] && sq1.size() > 0) void'(sq1.pop_front());
    if (req_ready[2] && sq2.size() > 0) void'(sq2.pop_front());
    drive();
    @(negedge clk);
    if (uart_transmit) begin
      if (exp_q.size() == 0) begin
        check("strobe_unexpected", 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("strobe_byte", 32'(uart_tx_byte), 32'(e[7:0]));
        check("strobe_grant", 32'(grant), 32'(e[15:8]));
      end
    end
    if (|req_ready) begin
      check("ready_uart_idle", 32'(uart_tx_busy), 32'(0));
      check("ready_is_grant", 32'(req_ready), 32'(grant));
    end
  endtask

  task automatic check_reset();
    check("rst_grant", 32'(grant), 32'(0));
    check("rst_ready", 32'(req_ready), 32'(0));
    check("rst_transmit", 32'(uart_transmit), 32'(0));
    check("rst_timeout", 32'(timeout_err), 32'(0));
    check("rst_byte", 32'(uart_tx_byte), 32'(0));
    check("rst_state", 32'(dbg_state), 32'(IDLE));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sq0.delete(); sq1.delete(); sq2.delete(); exp_q.delete();
    lk = '0;
    model_en = 1'b1;
    drive();
    @(posedge clk);
    @(negedge clk);
    check_reset();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic wait_state(input string tag, input arb_state_e st, input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (dbg_state == st) break;
    end
    check(tag, 32'(dbg_state), 32'(st));
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (exp_q.size() == 0 && sq0.size() == 0 && sq1.size() == 0 && sq2.size() == 0 &&
          dbg_state == IDLE && !uart_tx_busy) break;
    end
    check(tag, 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    logic [7:0] r0, r1, r2, r3;
    reset    = 1'b1;
    model_en = 1'b1;
    lk       = '0;
    drive();

    // single requester: latency and no accept while the uart is busy
    do_reset();
    sq0.push_back(8'h41); sq0.push_back(8'h42);
    expect_tx(3'b001, 8'h41); expect_tx(3'b001, 8'h42);
    drive();
    tick();
    check("single_ready", 32'(req_ready), 32'(3'b001));
    check("single_launch", 32'(dbg_state), 32'(LAUNCH));
    check("single_no_strobe_yet", 32'(uart_transmit), 32'(0));
    tick();
    check("single_strobe", 32'(uart_transmit), 32'(1));
    check("single_byte", 32'(uart_tx_byte), 32'(8'h41));
    check("single_ready_drop", 32'(req_ready), 32'(0));
    drain("single_drain", 200);

    // both valid, no lock: strict alternation
    do_reset();
    sq0.push_back("A"); sq0.push_back("B");
    sq1.push_back("x"); sq1.push_back("y");
    expect_tx(3'b001, "A"); expect_tx(3'b010, "x");
    expect_tx(3'b001, "B"); expect_tx(3'b010, "y");
    drive();
    drain("rr_drain", 300);

    // lock: req1 sends "HI\n" uninterrupted while req0 waits
    do_reset();
    lk = 3'b010;
    sq1.push_back("H"); sq1.push_back("I"); sq1.push_back(8'h0a);
    expect_tx(3'b010, "H"); expect_tx(3'b010, "I"); expect_tx(3'b010, 8'h0a);
    expect_tx(3'b001, "Z");
    drive();
    tick();
    check("lock_first_ready", 32'(req_ready), 32'(3'b010));
    sq0.push_back("Z");
    drive();
    wait_state("lock_reach_done", WAIT_DONE, 40);
    wait_state("lock_reach_idle", IDLE, 40);
    check("lock_grant_gap", 32'(grant), 32'(3'b010));
    drain("lock_drain", 300);
    check("lock_released", 32'(grant), 32'(0));

    // timeout: uart never raises busy
    do_reset();
    model_en = 1'b0;
    sq0.push_back(8'h55);
    expect_tx(3'b001, 8'h55);
    drive();
    tick();
    tick();
    check("tmo_wait_busy", 32'(dbg_state), 32'(WAIT_BUSY));
    for (int k = 1; k <= TMO; k++) begin
      tick();
      if (k == TMO - 1) check("tmo_not_early", 32'(timeout_err), 32'(0));
    end
    check("tmo_pulse", 32'(timeout_err), 32'(1));
    check("tmo_grant", 32'(grant), 32'(0));
    check("tmo_idle", 32'(dbg_state), 32'(IDLE));
    model_en = 1'b1;
    sq0.push_back(8'h66); sq1.push_back(8'h77);
    expect_tx(3'b010, 8'h77); expect_tx(3'b001, 8'h66);
    drive();
    tick();
    check("tmo_single_cycle", 32'(timeout_err), 32'(0));
    check("tmo_ptr_advanced", 32'(req_ready), 32'(3'b010));
    drain("tmo_drain", 300);

    // reset during WAIT_DONE
    do_reset();
    sq0.push_back(8'h31);
    expect_tx(3'b001, 8'h31);
    drive();
    wait_state("rst_reach_done", WAIT_DONE, 40);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    sq1.push_back(8'h32);
    expect_tx(3'b010, 8'h32);
    drive();
    tick();
    check("rst_then_req1", 32'(req_ready), 32'(3'b010));
    drain("rst_drain", 200);

    // requests on 0 and 2 only: rotation 0,2,0,2 with pointer wrap
    do_reset();
    r0 = 8'($urandom_range(0, 255)); r1 = 8'($urandom_range(0, 255));
    r2 = 8'($urandom_range(0, 255)); r3 = 8'($urandom_range(0, 255));
    sq0.push_back(r0); sq0.push_back(r1);
    sq2.push_back(r2); sq2.push_back(r3);
    expect_tx(3'b001, r0); expect_tx(3'b100, r2);
    expect_tx(3'b001, r1); expect_tx(3'b100, r3);
    drive();
    drain("wrap_drain", 300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
